fetch_unit: RTL and testbench

Instruction fetch stage: the producer that feeds `decode` its `instr_in`. It owns the program counter, issues word reads to instruction memory over a req/ack handshake, and buffers returned instructions in a 2-entry queue. It presents each instruction with its PC to decode under a valid/stall handshake, and accepts PC redirects from `execute` (branches and jumps), discarding any wrong-path data.

---
 rtl/riscv_pkg.sv | 18 +
 rtl/fetch_fifo.sv | 77 +++++++
 rtl/fetch_unit.sv | 110 +++++++++++
 tb/tb_fetch_unit.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared types and constants for the front end of the RV32 pipeline.
package riscv_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DROP
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous queue of fetched {pc, instr} entries; head is visible
// combinationally from registered storage, flush empties it in one cycle.
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           push,
  input  logic           pop,
  input  logic           flush,
  input  fetch_entry_t   push_data,
  output fetch_entry_t   head,
  output logic [CW-1:0]  count,
  output logic           empty,
  output logic           full
);

  fetch_entry_t      mem_reg [DEPTH];
  logic [PW-1:0]     wr_ptr_reg, wr_ptr_next;
  logic [PW-1:0]     rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0]     count_reg, count_next;
  logic              do_push, do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty = (count_reg == '0);
  assign full  = (count_reg == CW'(DEPTH));
  assign count = count_reg;
  assign head  = mem_reg[rd_ptr_reg];

  // Flush wins over both sides; a push into a full queue is only taken
  // when the head leaves in the same cycle.
  assign do_pop  = pop && !flush && !empty;
  assign do_push = push && !flush && (!full || do_pop);

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (flush) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      count_next  = '0;
    end else begin
      if (do_push) wr_ptr_next = ptr_inc(wr_ptr_reg);
      if (do_pop)  rd_ptr_next = ptr_inc(rd_ptr_reg);
      case ({do_push, do_pop})
        2'b10:   count_next = count_reg + CW'(1);
        2'b01:   count_next = count_reg - CW'(1);
        default: count_next = count_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_reg[wr_ptr_reg] <= push_data;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, reads imem over req/ack, buffers words in
// a small queue for decode and handles redirects from execute.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_out,
  output logic [31:0] imem_addr_out,
  input  logic        imem_ack_in,
  input  logic [31:0] imem_rdata_in,
  input  logic        stall_in,
  input  logic        branch_in,
  input  logic [31:0] branch_pc_in,
  output logic        valid_out,
  output logic [31:0] instr_out,
  output logic [31:0] pc_out
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);
  localparam logic [31:0] START_PC = {RESET_PC[31:2], 2'b00};

  fetch_state_e  state_reg, state_next;
  logic [31:0]   fetch_pc_reg, fetch_pc_next;
  logic [31:0]   drop_addr_reg, drop_addr_next;
  logic [31:0]   last_pc_reg;

  logic          push, pop;
  fetch_entry_t  push_data, head;
  logic [CW-1:0] count;
  logic          empty, full;
  logic [CW:0]   count_after;
  logic          unused_pc_bits;

  assign unused_pc_bits = ^branch_pc_in[1:0];

  // A redirect discards anything returning this cycle and anything queued.
  assign push      = (state_reg == FETCH) && imem_ack_in && !branch_in;
  assign pop       = valid_out && !stall_in && !branch_in;
  assign push_data = '{pc: fetch_pc_reg, instr: imem_rdata_in};

  assign count_after = {1'b0, count} + {{CW{1'b0}}, push} - {{CW{1'b0}}, pop};

  fetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .pop      (pop),
    .flush    (branch_in),
    .push_data(push_data),
    .head     (head),
    .count    (count),
    .empty    (empty),
    .full     (full)
  );

  always_comb begin
    state_next     = state_reg;
    fetch_pc_next  = fetch_pc_reg;
    drop_addr_next = drop_addr_reg;
    case (state_reg)
      IDLE: begin
        if (branch_in || !full) state_next = FETCH;
      end
      FETCH: begin
        if (imem_ack_in) begin
          fetch_pc_next = fetch_pc_reg + 32'd4;
          state_next    = (branch_in || (count_after < DEPTH_C)) ? FETCH : IDLE;
        end else if (branch_in) begin
          // The in-flight read must finish at its original address.
          state_next     = DROP;
          drop_addr_next = fetch_pc_reg;
        end
      end
      DROP: begin
        if (imem_ack_in) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (branch_in) fetch_pc_next = {branch_pc_in[31:2], 2'b00};
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg     <= IDLE;
      fetch_pc_reg  <= START_PC;
      drop_addr_reg <= START_PC;
      last_pc_reg   <= START_PC;
    end else begin
      state_reg     <= state_next;
      fetch_pc_reg  <= fetch_pc_next;
      drop_addr_reg <= drop_addr_next;
      last_pc_reg   <= pc_out;
    end
  end

  assign imem_req_out  = (state_reg != IDLE);
  assign imem_addr_out = (state_reg == DROP) ? drop_addr_reg : fetch_pc_reg;

  assign valid_out = !empty;
  assign instr_out = empty ? NOP_INSTR : head.instr;
  assign pc_out    = empty ? last_pc_reg : head.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: streaming, stall backpressure, slow memory,
// redirects with and without a coincident ack, mid-fetch reset, PC wrap.
module tb_fetch_unit;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        imem_req_out;
  logic [31:0] imem_addr_out;
  logic        imem_ack_in;
  logic [31:0] imem_rdata_in;
  logic        stall_in = 1'b0;
  logic        branch_in = 1'b0;
  logic [31:0] branch_pc_in = 32'h0;
  logic        valid_out;
  logic [31:0] instr_out;
  logic [31:0] pc_out;
  logic        ack_en = 1'b1;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  // Memory model: word at index i is 0x00100093 + i*0x8080.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h0010_0093 + {2'b00, a[31:2]} * 32'h0000_8080;
  endfunction

  assign imem_ack_in   = ack_en;
  assign imem_rdata_in = imem_ack_in ? mem_word(imem_addr_out) : 32'hDEAD_BEEF;

  fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .imem_req_out (imem_req_out),
    .imem_addr_out(imem_addr_out),
    .imem_ack_in  (imem_ack_in),
    .imem_rdata_in(imem_rdata_in),
    .stall_in     (stall_in),
    .branch_in    (branch_in),
    .branch_pc_in (branch_pc_in),
    .valid_out    (valid_out),
    .instr_out    (instr_out),
    .pc_out       (pc_out)
  );

  always @(negedge clk)
    if (reset && valid_out && !stall_in && !branch_in)
      $display("[%0t] deliver pc=%h instr=%h", $time, pc_out, instr_out);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    branch_in = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0; ack_en = 1'b1; stall_in = 1'b0; branch_in = 1'b0;
    tick(); tick();
    compared++; if (valid_out !== 1'b0) begin mismatched++; $display("FAIL reset_valid: got %b expected 0", valid_out); end
    compared++; if (instr_out !== 32'h0000_0013) begin mismatched++; $display("FAIL reset_instr: got %h expected 00000013", instr_out); end
    compared++; if (pc_out !== 32'h0) begin mismatched++; $display("FAIL reset_pc: got %h expected 00000000", pc_out); end
    compared++; if (imem_req_out !== 1'b0) begin mismatched++; $display("FAIL reset_req: got %b expected 0", imem_req_out); end
    compared++; if (imem_addr_out !== 32'h0) begin mismatched++; $display("FAIL reset_addr: got %h expected 00000000", imem_addr_out); end
    $display("test_reset done");
  endtask

  task automatic test_stream();
    ack_en = 1'b1; stall_in = 1'b0;
    do_reset();
    tick();
    compared++; if (imem_req_out !== 1'b1) begin mismatched++; $display("FAIL stream_first_req: got %b expected 1", imem_req_out); end
    compared++; if (imem_addr_out !== 32'h0) begin mismatched++; $display("FAIL stream_addr0: got %h expected 00000000", imem_addr_out); end
    compared++; if (valid_out !== 1'b0) begin mismatched++; $display("FAIL stream_valid_early: got %b expected 0", valid_out); end
    tick();
    compared++; if (imem_addr_out !== 32'h4) begin mismatched++; $display("FAIL stream_addr4: got %h expected 00000004", imem_addr_out); end
    compared++; if (valid_out !== 1'b1) begin mismatched++; $display("FAIL stream_valid: got %b expected 1", valid_out); end
    compared++; if (pc_out !== 32'h0) begin mismatched++; $display("FAIL stream_pc0: got %h expected 00000000", pc_out); end
    compared++; if (instr_out !== 32'h0010_0093) begin mismatched++; $display("FAIL stream_instr0: got %h expected 00100093", instr_out); end
    tick();
    compared++; if (imem_addr_out !== 32'h8) begin mismatched++; $display("FAIL stream_addr8: got %h expected 00000008", imem_addr_out); end
    compared++; if (pc_out !== 32'h4) begin mismatched++; $display("FAIL stream_pc4: got %h expected 00000004", pc_out); end
    compared++; if (instr_out !== 32'h0010_8113) begin mismatched++; $display("FAIL stream_instr1: got %h expected 00108113", instr_out); end
    tick();
    compared++; if (imem_addr_out !== 32'hC) begin mismatched++; $display("FAIL stream_addrC: got %h expected 0000000c", imem_addr_out); end
    compared++; if (pc_out !== 32'h8) begin mismatched++; $display("FAIL stream_pc8: got %h expected 00000008", pc_out); end
    compared++; if (instr_out !== 32'h0011_0193) begin mismatched++; $display("FAIL stream_instr2: got %h expected 00110193", instr_out); end
    $display("test_stream done");
  endtask

  task automatic test_stall();
    ack_en = 1'b1; stall_in = 1'b1;
    do_reset();
    tick();
    tick();
    compared++; if (imem_addr_out !== 32'h4) begin mismatched++; $display("FAIL stall_addr4: got %h expected 00000004", imem_addr_out); end
    tick();
    compared++; if (imem_req_out !== 1'b0) begin mismatched++; $display("FAIL stall_req_full: got %b expected 0", imem_req_out); end
    for (int i = 0; i < 2; i++) begin
      tick();
      compared++; if (imem_req_out !== 1'b0) begin mismatched++; $display("FAIL stall_req_hold%0d: got %b expected 0", i, imem_req_out); end
    end
    compared++; if (pc_out !== 32'h0) begin mismatched++; $display("FAIL stall_head_pc: got %h expected 00000000", pc_out); end
    compared++; if (instr_out !== 32'h0010_0093) begin mismatched++; $display("FAIL stall_head_instr: got %h expected 00100093", instr_out); end
    stall_in = 1'b0;
    tick();
    compared++; if (pc_out !== 32'h4) begin mismatched++; $display("FAIL stall_pop_pc4: got %h expected 00000004", pc_out); end
    compared++; if (instr_out !== 32'h0010_8113) begin mismatched++; $display("FAIL stall_pop_instr1: got %h expected 00108113", instr_out); end
    tick();
    compared++; if (valid_out !== 1'b0) begin mismatched++; $display("FAIL stall_drained: got %b expected 0", valid_out); end
    compared++; if (imem_req_out !== 1'b1 || imem_addr_out !== 32'h8) begin mismatched++; $display("FAIL stall_resume: got req=%b addr=%h expected req=1 addr=00000008", imem_req_out, imem_addr_out); end
    tick();
    compared++; if (pc_out !== 32'h8 || instr_out !== 32'h0011_0193) begin mismatched++; $display("FAIL stall_next: got pc=%h instr=%h expected pc=00000008 instr=00110193", pc_out, instr_out); end
    $display("test_stall done");
  endtask

  task automatic test_ack_delay();
    ack_en = 1'b1; stall_in = 1'b0;
    do_reset();
    tick();
    tick();
    ack_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      compared++; if (imem_req_out !== 1'b1 || imem_addr_out !== 32'h4) begin mismatched++; $display("FAIL delay_hold%0d: got req=%b addr=%h expected req=1 addr=00000004", i, imem_req_out, imem_addr_out); end
      compared++; if (valid_out !== 1'b0) begin mismatched++; $display("FAIL delay_gap_valid%0d: got %b expected 0", i, valid_out); end
    end
    compared++; if (instr_out !== 32'h0000_0013 || pc_out !== 32'h0) begin mismatched++; $display("FAIL delay_empty_out: got pc=%h instr=%h expected pc=00000000 instr=00000013", pc_out, instr_out); end
    ack_en = 1'b1;
    tick();
    compared++; if (valid_out !== 1'b1 || pc_out !== 32'h4 || instr_out !== 32'h0010_8113) begin mismatched++; $display("FAIL delay_arrive: got v=%b pc=%h instr=%h expected v=1 pc=00000004 instr=00108113", valid_out, pc_out, instr_out); end
    $display("test_ack_delay done");
  endtask

  task automatic test_redirect_pending();
    int n;
    ack_en = 1'b1; stall_in = 1'b0;
    do_reset();
    tick(); tick(); tick();
    compared++; if (imem_addr_out !== 32'h8) begin mismatched++; $display("FAIL redir_pre_addr: got %h expected 00000008", imem_addr_out); end
    ack_en = 1'b0; branch_in = 1'b1; branch_pc_in = 32'h0000_0103;
    tick();
    branch_in = 1'b0;
    compared++; if (valid_out !== 1'b0) begin mismatched++; $display("FAIL redir_flush: got %b expected 0", valid_out); end
    compared++; if (pc_out !== 32'h4 || instr_out !== 32'h0000_0013) begin mismatched++; $display("FAIL redir_hold_pc: got pc=%h instr=%h expected pc=00000004 instr=00000013", pc_out, instr_out); end
    compared++; if (imem_req_out !== 1'b1 || imem_addr_out !== 32'h8) begin mismatched++; $display("FAIL redir_drop_addr: got req=%b addr=%h expected req=1 addr=00000008", imem_req_out, imem_addr_out); end
    tick();
    compared++; if (imem_req_out !== 1'b1 || imem_addr_out !== 32'h8) begin mismatched++; $display("FAIL redir_drop_stable: got req=%b addr=%h expected req=1 addr=00000008", imem_req_out, imem_addr_out); end
    ack_en = 1'b1;
    tick();
    compared++; if (valid_out !== 1'b0) begin mismatched++; $display("FAIL redir_dropped_data: got %b expected 0", valid_out); end
    n = 0;
    while (imem_req_out !== 1'b1 && n < 4) begin
      tick();
      n++;
    end
    compared++; if (imem_req_out !== 1'b1) begin mismatched++; $display("FAIL redir_req_timeout: got req=%b expected 1", imem_req_out); end
    compared++; if (imem_addr_out !== 32'h100) begin mismatched++; $display("FAIL redir_target: got %h expected 00000100", imem_addr_out); end
    tick();
    compared++; if (valid_out !== 1'b1 || pc_out !== 32'h100 || instr_out !== 32'h0030_2093) begin mismatched++; $display("FAIL redir_first: got v=%b pc=%h instr=%h expected v=1 pc=00000100 instr=00302093", valid_out, pc_out, instr_out); end
    $display("test_redirect_pending done");
  endtask

  task automatic test_redirect_on_ack();
    ack_en = 1'b1; stall_in = 1'b0;
    do_reset();
    tick(); tick(); tick(); tick();
    compared++; if (valid_out !== 1'b1 || imem_addr_out !== 32'hC) begin mismatched++; $display("FAIL rack_pre: got v=%b addr=%h expected v=1 addr=0000000c", valid_out, imem_addr_out); end
    branch_in = 1'b1; branch_pc_in = 32'h0000_0200;
    tick();
    branch_in = 1'b0;
    compared++; if (valid_out !== 1'b0) begin mismatched++; $display("FAIL rack_flush: got %b expected 0", valid_out); end
    compared++; if (imem_req_out !== 1'b1 || imem_addr_out !== 32'h200) begin mismatched++; $display("FAIL rack_req: got req=%b addr=%h expected req=1 addr=00000200", imem_req_out, imem_addr_out); end
    tick();
    compared++; if (valid_out !== 1'b1 || pc_out !== 32'h200 || instr_out !== 32'h0050_4093) begin mismatched++; $display("FAIL rack_first: got v=%b pc=%h instr=%h expected v=1 pc=00000200 instr=00504093", valid_out, pc_out, instr_out); end
    $display("test_redirect_on_ack done");
  endtask

  task automatic test_reset_mid_fetch();
    ack_en = 1'b1; stall_in = 1'b1;
    do_reset();
    tick(); tick();
    ack_en = 1'b0;
    tick();
    compared++; if (imem_req_out !== 1'b1 || imem_addr_out !== 32'h4 || valid_out !== 1'b1) begin mismatched++; $display("FAIL rmid_pre: got req=%b addr=%h v=%b expected req=1 addr=00000004 v=1", imem_req_out, imem_addr_out, valid_out); end
    reset = 1'b0;
    tick();
    ack_en = 1'b1;
    compared++; if (valid_out !== 1'b0 || instr_out !== 32'h0000_0013 || pc_out !== 32'h0) begin mismatched++; $display("FAIL rmid_outs: got v=%b pc=%h instr=%h expected v=0 pc=00000000 instr=00000013", valid_out, pc_out, instr_out); end
    compared++; if (imem_req_out !== 1'b0 || imem_addr_out !== 32'h0) begin mismatched++; $display("FAIL rmid_mem: got req=%b addr=%h expected req=0 addr=00000000", imem_req_out, imem_addr_out); end
    tick();
    compared++; if (valid_out !== 1'b0 || imem_req_out !== 1'b0) begin mismatched++; $display("FAIL rmid_late_ack: got v=%b req=%b expected v=0 req=0", valid_out, imem_req_out); end
    reset = 1'b1; stall_in = 1'b0;
    tick();
    compared++; if (imem_req_out !== 1'b1 || imem_addr_out !== 32'h0 || valid_out !== 1'b0) begin mismatched++; $display("FAIL rmid_restart: got req=%b addr=%h v=%b expected req=1 addr=00000000 v=0", imem_req_out, imem_addr_out, valid_out); end
    tick();
    compared++; if (valid_out !== 1'b1 || pc_out !== 32'h0 || instr_out !== 32'h0010_0093) begin mismatched++; $display("FAIL rmid_first: got v=%b pc=%h instr=%h expected v=1 pc=00000000 instr=00100093", valid_out, pc_out, instr_out); end
    $display("test_reset_mid_fetch done");
  endtask

  task automatic test_wrap();
    ack_en = 1'b1; stall_in = 1'b0;
    do_reset();
    branch_in = 1'b1; branch_pc_in = 32'hFFFF_FFFF;
    tick();
    branch_in = 1'b0;
    compared++; if (imem_req_out !== 1'b1 || imem_addr_out !== 32'hFFFF_FFFC) begin mismatched++; $display("FAIL wrap_idle_redir: got req=%b addr=%h expected req=1 addr=fffffffc", imem_req_out, imem_addr_out); end
    tick();
    compared++; if (imem_addr_out !== 32'h0) begin mismatched++; $display("FAIL wrap_addr: got %h expected 00000000", imem_addr_out); end
    compared++; if (pc_out !== 32'hFFFF_FFFC || instr_out !== 32'h000F_8013) begin mismatched++; $display("FAIL wrap_top: got pc=%h instr=%h expected pc=fffffffc instr=000f8013", pc_out, instr_out); end
    tick();
    compared++; if (pc_out !== 32'h0 || instr_out !== 32'h0010_0093 || imem_addr_out !== 32'h4) begin mismatched++; $display("FAIL wrap_zero: got pc=%h instr=%h addr=%h expected pc=00000000 instr=00100093 addr=00000004", pc_out, instr_out, imem_addr_out); end
    $display("test_wrap done");
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_ack_delay();
    test_redirect_pending();
    test_redirect_on_ack();
    test_reset_mid_fetch();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "simulation time limit reached");
  end

endmodule
